// File: rtl/lap_capture_pkg.sv
// Shared definitions for the stopwatch front end (lap_capture).
//   state_t        : run/pause/idle FSM encoding
//   BCD_DIGIT_MAX  : largest value a BCD digit may hold
//   TIME_W         : width of the two-digit BCD time word
//   bcd_inc()      : two-digit BCD increment, 99 wraps to 00
package lap_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0]  BCD_DIGIT_MAX = 4'd9;
  localparam int unsigned TIME_W        = 8;

  function automatic logic [TIME_W-1:0] bcd_inc(input logic [TIME_W-1:0] t);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = t[7:4];
    units = t[3:0];
    if (units == BCD_DIGIT_MAX) begin
      units = '0;
      tens  = (tens == BCD_DIGIT_MAX) ? '0 : tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/lap_capture_debounce.sv
// btn_debounce: conditions one raw push-button.
//   clk, reset : system clock, asynchronous active-high reset
//   btn        : raw button level, asynchronous to clk
//   pulse      : one-cycle registered strobe on each accepted press (0->1)
// A new level is accepted only after it has differed from the debounced
// level for DEBOUNCE_CYCLES consecutive cycles; releases give no pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      pulse   <= level & ~level_d;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/lap_capture.sv
// lap_capture: stopwatch front end feeding the lap stash.
//   clk, reset   : system clock, asynchronous active-high reset
//   btn_run      : raw start/pause button
//   btn_lap      : raw lap (RUN) / clear (PAUSE) button
//   btn_next     : raw browse button
//   time_bcd     : live two-digit BCD seconds, [7:4] tens, [3:0] units
//   running      : high while the FSM is in RUN
//   sample_out   : last captured lap time (BCD), held until next capture
//   sample_valid : one-cycle strobe, cycle after a lap is captured
//   next_pulse   : one-cycle browse strobe, aligned like sample_valid
module lap_capture
  import lap_capture_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC   = 100000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_run,
  input  logic              btn_lap,
  input  logic              btn_next,
  output logic [TIME_W-1:0] time_bcd,
  output logic              running,
  output logic [TIME_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              next_pulse
);

  localparam int unsigned PRESC_W = $clog2(TICKS_PER_SEC);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

  logic               run_p;
  logic               lap_p;
  logic               next_p;
  state_t             state;
  state_t             state_next;
  logic               capture;
  logic               clear_time;
  logic               tick;
  logic [PRESC_W-1:0] presc;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk(clk), .reset(reset), .btn(btn_run), .pulse(run_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk(clk), .reset(reset), .btn(btn_lap), .pulse(lap_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .reset(reset), .btn(btn_next), .pulse(next_p)
  );

  // run wins over lap in PAUSE (no clear); in RUN both act together.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    clear_time = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run_p) state_next = ST_RUN;
      end
      ST_RUN: begin
        capture = lap_p;
        if (run_p) state_next = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (run_p) begin
          state_next = ST_RUN;
        end else if (lap_p) begin
          clear_time = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == ST_RUN);
    end
  end

  assign tick = (state == ST_RUN) && (presc == PRESC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      time_bcd <= '0;
    end else if (clear_time) begin
      presc    <= '0;
      time_bcd <= '0;
    end else if (state == ST_RUN) begin
      presc <= tick ? '0 : presc + PRESC_W'(1);
      if (tick) time_bcd <= bcd_inc(time_bcd);
    end
  end

  // sample_out takes the pre-increment time_bcd even when a tick lands
  // on the capture edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
      next_pulse   <= 1'b0;
    end else begin
      if (capture) sample_out <= time_bcd;
      sample_valid <= capture;
      next_pulse   <= next_p;
    end
  end

endmodule

// File: tb/tb_lap_capture.sv
// Directed bench for lap_capture with TICKS_PER_SEC=4, DEBOUNCE_CYCLES=3.
// From a button change driven at a falling edge, the press pulse is seen
// after 6 rising edges and its registered effect after 7.
module tb_lap_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_run;
  logic       btn_lap;
  logic       btn_next;
  logic [7:0] time_bcd;
  logic       running;
  logic [7:0] sample_out;
  logic       sample_valid;
  logic       next_pulse;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  lap_capture #(
    .TICKS_PER_SEC(4),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_run(btn_run),
    .btn_lap(btn_lap),
    .btn_next(btn_next),
    .time_bcd(time_bcd),
    .running(running),
    .sample_out(sample_out),
    .sample_valid(sample_valid),
    .next_pulse(next_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Polls at falling edges until time_bcd shows v (first cycle after the tick).
  task automatic wait_time(input logic [7:0] v, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (time_bcd !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_time", time_bcd, v);
  endtask

  initial begin
    int unsigned rises;
    int unsigned cnt;
    logic        prev;

    reset    = 1'b1;
    btn_run  = 1'b0;
    btn_lap  = 1'b0;
    btn_next = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_time", time_bcd, 8'h00);
    chk("rst_running", {7'd0, running}, 8'd0);
    chk("rst_sample", sample_out, 8'h00);
    chk("rst_valid", {7'd0, sample_valid}, 8'd0);
    chk("rst_next", {7'd0, next_pulse}, 8'd0);
    reset = 1'b0;

    // 1: start from IDLE, running rises once, first ticks 4 and 8 cycles later
    btn_run = 1'b1;
    prev    = 1'b0;
    rises   = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (running && !prev) rises++;
      prev = running;
      if (k == 6)  chk("t1_run_before", {7'd0, running}, 8'd0);
      if (k == 7)  chk("t1_run_rise", {7'd0, running}, 8'd1);
      if (k == 10) begin
        chk("t1_time_00", time_bcd, 8'h00);
        btn_run = 1'b0;
      end
      if (k == 11) chk("t1_time_01", time_bcd, 8'h01);
      if (k == 14) chk("t1_time_01_hold", time_bcd, 8'h01);
      if (k == 15) chk("t1_time_02", time_bcd, 8'h02);
    end
    chk("t1_rises", rises[7:0], 8'd1);

    // 2: units carry into tens, and 99 wraps to 00
    wait_time(8'h09, 100);
    repeat (3) @(negedge clk);
    chk("t2_hold_09", time_bcd, 8'h09);
    @(negedge clk);
    chk("t2_carry_10", time_bcd, 8'h10);
    wait_time(8'h99, 500);
    repeat (4) @(negedge clk);
    chk("t2_wrap_00", time_bcd, 8'h00);

    // 3: laps captured at 23 and 27; capture edge coincides with a tick
    wait_time(8'h22, 200);
    @(negedge clk);
    btn_lap = 1'b1;
    repeat (6) @(negedge clk);
    chk("t3_valid_early", {7'd0, sample_valid}, 8'd0);
    @(negedge clk);
    chk("t3_valid_23", {7'd0, sample_valid}, 8'd1);
    chk("t3_sample_23", sample_out, 8'h23);
    chk("t3_time_24", time_bcd, 8'h24);
    btn_lap = 1'b0;
    @(negedge clk);
    chk("t3_valid_one", {7'd0, sample_valid}, 8'd0);
    chk("t3_sample_hold", sample_out, 8'h23);
    wait_time(8'h26, 100);
    @(negedge clk);
    btn_lap = 1'b1;
    repeat (6) @(negedge clk);
    chk("t3b_valid_early", {7'd0, sample_valid}, 8'd0);
    @(negedge clk);
    chk("t3b_valid_27", {7'd0, sample_valid}, 8'd1);
    chk("t3b_sample_27", sample_out, 8'h27);
    chk("t3b_time_28", time_bcd, 8'h28);
    btn_lap = 1'b0;
    repeat (6) @(negedge clk);

    // 4: short lap glitch rejected; bouncing next gives one pulse
    btn_lap = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (sample_valid) cnt++;
      if (k == 2) btn_lap = 1'b0;
    end
    chk("t4_glitch_valid", cnt[7:0], 8'd0);
    btn_next = 1'b1;
    @(negedge clk);
    btn_next = 1'b0;
    @(negedge clk);
    btn_next = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (next_pulse) cnt++;
      if (k == 7) chk("t4_next_time", {7'd0, next_pulse}, 8'd1);
    end
    chk("t4_next_count", cnt[7:0], 8'd1);
    btn_next = 1'b0;

    // 5: pause at 05 holds, lap in PAUSE clears to IDLE without capture
    wait_time(8'h04, 600);
    btn_run = 1'b1;
    repeat (6) @(negedge clk);
    chk("t5_still_run", {7'd0, running}, 8'd1);
    @(negedge clk);
    chk("t5_paused", {7'd0, running}, 8'd0);
    chk("t5_time_05", time_bcd, 8'h05);
    btn_run = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_hold_05", time_bcd, 8'h05);
    btn_lap = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (sample_valid) cnt++;
      if (k == 6) chk("t5_before_clear", time_bcd, 8'h05);
      if (k == 7) begin
        chk("t5_cleared", time_bcd, 8'h00);
        chk("t5_idle_running", {7'd0, running}, 8'd0);
        btn_lap = 1'b0;
      end
    end
    chk("t5_no_valid", cnt[7:0], 8'd0);
    chk("t5_idle_hold", time_bcd, 8'h00);

    // 6: asynchronous reset mid-count while lap is debouncing
    btn_run = 1'b1;
    repeat (7) @(negedge clk);
    chk("t6_run", {7'd0, running}, 8'd1);
    btn_run = 1'b0;
    wait_time(8'h42, 400);
    btn_lap = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_time", time_bcd, 8'h00);
    chk("t6_async_running", {7'd0, running}, 8'd0);
    chk("t6_async_sample", sample_out, 8'h00);
    chk("t6_async_valid", {7'd0, sample_valid}, 8'd0);
    chk("t6_async_next", {7'd0, next_pulse}, 8'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (sample_valid) cnt++;
    end
    chk("t6_no_valid", cnt[7:0], 8'd0);
    chk("t6_idle", {7'd0, running}, 8'd0);
    chk("t6_time", time_bcd, 8'h00);
    btn_lap = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
